// File: rtl/store_pkg.sv
// Shared definitions for the sub-word store unit: size encoding, FSM states
// and the byte-offset width helper.
package store_pkg;

  localparam logic [1:0] SZ_INV = 2'd0;
  localparam logic [1:0] SZ_B   = 2'd1;
  localparam logic [1:0] SZ_H   = 2'd2;
  localparam logic [1:0] SZ_W   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Number of byte-offset bits inside one memory word.
  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// Request/response and memory-port bundle of store_rmw_unit.
// slave = unit side, master = control FSM / memory side.
interface store_rmw_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] store_data;
  logic [1:0]        store_size;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  start, addr, store_data, store_size, mem_rdata,
    output busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output start, addr, store_data, store_size, mem_rdata,
    input  busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/store_merge.sv
// Combinational little-endian lane merge: overlays the byte, halfword or full
// word of store_data onto rdata at the lane picked by offset.
module store_merge
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF    = off_bits(DATA_W)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] store_data,
  input  logic [1:0]        size,
  input  logic [OFF-1:0]    offset,
  output logic [DATA_W-1:0] merged
);

  for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
    localparam logic [OFF-1:0] LANE = OFF'(gi);
    logic       hit;
    logic [7:0] src;

    // Halfword lanes ignore offset bit 0, so a misaligned half is truncated.
    always_comb begin
      hit = 1'b0;
      src = store_data[8*gi +: 8];
      case (size)
        SZ_B: begin
          hit = (offset == LANE);
          src = store_data[7:0];
        end
        SZ_H: begin
          hit = (offset[OFF-1:1] == LANE[OFF-1:1]);
          src = store_data[8*(gi%2) +: 8];
        end
        SZ_W:    hit = 1'b1;
        default: hit = 1'b0;
      endcase
    end

    assign merged[8*gi +: 8] = hit ? src : rdata[8*gi +: 8];
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Sub-word store unit: sb/sh via read-modify-write, sw as a direct write.
// Optional STORE_MISALIGN_TRAP_EN rejects misaligned half/word stores with err.
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  store_rmw_unit_if.slave  bus
);

  localparam int OFF   = off_bits(DATA_W);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        size_q, size_d;
  logic [OFF-1:0]    off_q, off_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] merged;

`ifdef STORE_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((bus.store_size == SZ_H) && bus.addr[0]) ||
                    ((bus.store_size == SZ_W) && (bus.addr[OFF-1:0] != '0));
`endif

  store_merge #(.DATA_W(DATA_W), .OFF(OFF)) u_merge (
    .rdata      (bus.mem_rdata),
    .store_data (data_q),
    .size       (size_q),
    .offset     (off_q),
    .merged     (merged)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    off_d       = off_q;
    data_d      = data_q;
    done_d      = 1'b0;
    err_d       = err_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          size_d     = bus.store_size;
          off_d      = bus.addr[OFF-1:0];
          data_d     = bus.store_data;
          err_d      = 1'b0;
          mem_addr_d = {bus.addr[ADDR_W-1:OFF], {OFF{1'b0}}};
          if (bus.store_size == SZ_INV) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
`ifdef STORE_MISALIGN_TRAP_EN
          end else if (misalign) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
`endif
          end else if (bus.store_size == SZ_W) begin
            state_d     = ST_WRITE;
            mem_wr_d    = 1'b1;
            mem_wdata_d = bus.store_data;
          end else begin
            state_d  = ST_READ;
            mem_rd_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      // Read data is valid in the last WAIT cycle; merge it straight into the write word.
      ST_WAIT: begin
        if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
          state_d     = ST_WRITE;
          mem_wr_d    = 1'b1;
          mem_wdata_d = merged;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      size_q      <= SZ_INV;
      off_q       <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      off_q       <= off_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: three instances (32b/lat1, 32b/lat3, 64b/lat1),
// a latency-accurate memory model and a done-driven scoreboard.
module tb_store_rmw_unit;
  import store_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  store_rmw_unit_if #(.DATA_W(32), .ADDR_W(32)) if0 ();
  store_rmw_unit_if #(.DATA_W(32), .ADDR_W(32)) if1 ();
  store_rmw_unit_if #(.DATA_W(64), .ADDR_W(32)) if2 ();

  store_rmw_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  store_rmw_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(3)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  store_rmw_unit #(.DATA_W(64), .ADDR_W(32), .MEM_LAT(1)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  // Stand-alone merge unit
  logic [31:0] m_rd, m_sd, m_out;
  logic [1:0]  m_sz, m_off;
  store_merge #(.DATA_W(32)) u_merge (.rdata(m_rd), .store_data(m_sd), .size(m_sz), .offset(m_off), .merged(m_out));

  logic        drv_start [3];
  logic [31:0] drv_addr  [3];
  logic [63:0] drv_data  [3];
  logic [1:0]  drv_size  [3];
  logic [63:0] mem_word  [3];
  logic [3:0]  pipe      [3];

  logic        mon_rd [3], mon_wr [3], mon_done [3], mon_err [3], mon_busy [3];
  logic [31:0] mon_addr  [3];
  logic [63:0] mon_wdata [3];

  assign if0.start = drv_start[0];  assign if0.addr = drv_addr[0];
  assign if0.store_data = drv_data[0][31:0];  assign if0.store_size = drv_size[0];
  assign if1.start = drv_start[1];  assign if1.addr = drv_addr[1];
  assign if1.store_data = drv_data[1][31:0];  assign if1.store_size = drv_size[1];
  assign if2.start = drv_start[2];  assign if2.addr = drv_addr[2];
  assign if2.store_data = drv_data[2];        assign if2.store_size = drv_size[2];

  // Memory returns the word only in the cycle MEM_LAT after mem_rd, garbage otherwise
  assign if0.mem_rdata = pipe[0][0] ? mem_word[0][31:0] : 32'hDEADBEEF;
  assign if1.mem_rdata = pipe[1][2] ? mem_word[1][31:0] : 32'hDEADBEEF;
  assign if2.mem_rdata = pipe[2][0] ? mem_word[2] : 64'hDEADBEEF_DEADBEEF;

  assign mon_rd[0] = if0.mem_rd;  assign mon_wr[0] = if0.mem_wr;  assign mon_done[0] = if0.done;
  assign mon_err[0] = if0.err;    assign mon_busy[0] = if0.busy;  assign mon_addr[0] = if0.mem_addr;
  assign mon_wdata[0] = {32'b0, if0.mem_wdata};
  assign mon_rd[1] = if1.mem_rd;  assign mon_wr[1] = if1.mem_wr;  assign mon_done[1] = if1.done;
  assign mon_err[1] = if1.err;    assign mon_busy[1] = if1.busy;  assign mon_addr[1] = if1.mem_addr;
  assign mon_wdata[1] = {32'b0, if1.mem_wdata};
  assign mon_rd[2] = if2.mem_rd;  assign mon_wr[2] = if2.mem_wr;  assign mon_done[2] = if2.done;
  assign mon_err[2] = if2.err;    assign mon_busy[2] = if2.busy;  assign mon_addr[2] = if2.mem_addr;
  assign mon_wdata[2] = if2.mem_wdata;

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (reset) pipe[d] <= 4'b0;
      else       pipe[d] <= {pipe[d][2:0], mon_rd[d]};
    end
  end

  typedef struct {
    int          dut;
    logic [31:0] addr;
    logic [63:0] sdata;
    logic [1:0]  size;
    logic [63:0] word;
    int          rd;
    int          wr;
    logic [31:0] waddr;
    logic [63:0] wdata;
    logic        err;
    int          lat;
  } req_t;

  typedef struct {
    int          dut;
    int          t0;
    int          rd;
    int          wr;
    logic [31:0] waddr;
    logic [63:0] wdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] sd;
    logic [1:0]  sz;
    logic [1:0]  off;
    logic [31:0] exp;
  } mv_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard: tally memory strobes per request, compare on done
  int          rd_cnt [3];
  int          wr_cnt [3];
  logic [31:0] wr_addr [3];
  logic [63:0] wr_data [3];
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        rd_cnt[d] = 0;
        wr_cnt[d] = 0;
      end else begin
        if (mon_rd[d]) begin
          chk($sformatf("rd_expected_d%0d", d), 64'(exp_q.size() != 0), 64'd1);
          rd_cnt[d]++;
        end
        if (mon_wr[d]) begin
          chk($sformatf("wr_expected_d%0d", d), 64'(exp_q.size() != 0), 64'd1);
          wr_cnt[d]++;
          wr_addr[d] = mon_addr[d];
          wr_data[d] = mon_wdata[d];
        end
        if (mon_done[d]) begin
          chk($sformatf("done_expected_d%0d", d), 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            $display("txn dut=%0d t0=%0d lat=%0d rd=%0d wr=%0d addr=%h wdata=%h err=%b",
                     d, e.t0, cyc - e.t0, rd_cnt[d], wr_cnt[d], wr_addr[d], wr_data[d], mon_err[d]);
            chk("dut_id", 64'(d), 64'(e.dut));
            chk("done_cycle", 64'(cyc - e.t0), 64'(e.lat));
            chk("rd_count", 64'(rd_cnt[d]), 64'(e.rd));
            chk("wr_count", 64'(wr_cnt[d]), 64'(e.wr));
            chk("err", 64'(mon_err[d]), 64'(e.err));
            if (e.wr != 0) begin
              chk("mem_addr", 64'(wr_addr[d]), 64'(e.waddr));
              chk("mem_wdata", wr_data[d], e.wdata);
            end
          end
          rd_cnt[d] = 0;
          wr_cnt[d] = 0;
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (mon_busy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (mon_busy[d]) chk("idle_timeout", 64'(mon_busy[d]), 64'd0);
  endtask

  // Drives one start pulse (cycle c0) and returns at the negedge of c1.
  task automatic send(input req_t r);
    exp_t e;
    drain();
    @(negedge clk);
    wait_idle(r.dut);
    mem_word[r.dut]  = r.word;
    drv_addr[r.dut]  = r.addr;
    drv_data[r.dut]  = r.sdata;
    drv_size[r.dut]  = r.size;
    drv_start[r.dut] = 1'b1;
    e = '{dut: r.dut, t0: cyc, rd: r.rd, wr: r.wr, waddr: r.waddr,
          wdata: r.wdata, err: r.err, lat: r.lat};
    exp_q.push_back(e);
    @(negedge clk);
    drv_start[r.dut] = 1'b0;
  endtask

  req_t vec [14];
  mv_t  mvec [6];
  req_t r;
  exp_t e2;

  initial begin
    for (int d = 0; d < 3; d++) begin
      drv_start[d] = 1'b0; drv_addr[d] = '0; drv_data[d] = '0;
      drv_size[d]  = SZ_INV; mem_word[d] = '0;
    end

    mvec[0] = '{32'h11223344, 32'hAABBCCDD, SZ_B, 2'd0, 32'h112233DD};
    mvec[1] = '{32'h11223344, 32'hAABBCCDD, SZ_B, 2'd2, 32'h11DD3344};
    mvec[2] = '{32'h11223344, 32'h0000BEEF, SZ_H, 2'd2, 32'hBEEF3344};
    mvec[3] = '{32'h11223344, 32'h0000BEEF, SZ_H, 2'd0, 32'h1122BEEF};
    mvec[4] = '{32'h11223344, 32'h0000BEEF, SZ_H, 2'd1, 32'h1122BEEF};
    mvec[5] = '{32'h11223344, 32'hCAFEF00D, SZ_W, 2'd1, 32'hCAFEF00D};

    //          dut addr          sdata                  size    word                   rd wr waddr         wdata                  err   lat
    vec[0]  = '{0, 32'h103, 64'hAABBCCDD,         SZ_B,   64'h11223344,         1, 1, 32'h100, 64'hDD223344,         1'b0, 4};
    vec[1]  = '{0, 32'h102, 64'h0000BEEF,         SZ_H,   64'h11223344,         1, 1, 32'h100, 64'hBEEF3344,         1'b0, 4};
    vec[2]  = '{0, 32'h200, 64'hCAFEF00D,         SZ_W,   64'h0,                0, 1, 32'h200, 64'hCAFEF00D,         1'b0, 2};
    vec[3]  = '{0, 32'h300, 64'h12345678,         SZ_INV, 64'h0,                0, 0, 32'h0,   64'h0,                1'b1, 1};
    vec[4]  = '{0, 32'h100, 64'h00000055,         SZ_B,   64'hFFFFFFFF,         1, 1, 32'h100, 64'hFFFFFF55,         1'b0, 4};
    vec[5]  = '{0, 32'h101, 64'h12345678,         SZ_B,   64'h0,                1, 1, 32'h100, 64'h00007800,         1'b0, 4};
`ifdef STORE_MISALIGN_TRAP_EN
    vec[6]  = '{0, 32'h101, 64'h0000BEEF,         SZ_H,   64'h11223344,         0, 0, 32'h0,   64'h0,                1'b1, 1};
    vec[7]  = '{0, 32'h202, 64'h12345678,         SZ_W,   64'h0,                0, 0, 32'h0,   64'h0,                1'b1, 1};
`else
    vec[6]  = '{0, 32'h101, 64'h0000BEEF,         SZ_H,   64'h11223344,         1, 1, 32'h100, 64'h1122BEEF,         1'b0, 4};
    vec[7]  = '{0, 32'h202, 64'h12345678,         SZ_W,   64'h0,                0, 1, 32'h200, 64'h12345678,         1'b0, 2};
`endif
    vec[8]  = '{1, 32'h102, 64'h0000BEEF,         SZ_H,   64'h11223344,         1, 1, 32'h100, 64'hBEEF3344,         1'b0, 6};
    vec[9]  = '{1, 32'h100, 64'h000000AB,         SZ_B,   64'h11223344,         1, 1, 32'h100, 64'h112233AB,         1'b0, 6};
    vec[10] = '{2, 32'h107, 64'h00000000000000AA, SZ_B,   64'h1122334455667788, 1, 1, 32'h100, 64'hAA22334455667788, 1'b0, 4};
    vec[11] = '{2, 32'h10A, 64'h000000000000BEEF, SZ_H,   64'h1122334455667788, 1, 1, 32'h108, 64'h11223344BEEF7788, 1'b0, 4};
    vec[12] = '{2, 32'h110, 64'h0123456789ABCDEF, SZ_W,   64'h0,                0, 1, 32'h110, 64'h0123456789ABCDEF, 1'b0, 2};
    vec[13] = '{1, 32'h104, 64'h0,                SZ_INV, 64'h0,                0, 0, 32'h0,   64'h0,                1'b1, 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",  64'(if0.busy), 64'd0);
    chk("rst_done",  64'(if0.done), 64'd0);
    chk("rst_err",   64'(if0.err), 64'd0);
    chk("rst_mem_rd", 64'(if0.mem_rd), 64'd0);
    chk("rst_mem_wr", 64'(if0.mem_wr), 64'd0);
    chk("rst_mem_addr", 64'(if0.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(if0.mem_wdata), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      m_rd = mvec[i].rd; m_sd = mvec[i].sd; m_sz = mvec[i].sz; m_off = mvec[i].off;
      #1;
      chk($sformatf("merge_%0d", i), 64'(m_out), 64'(mvec[i].exp));
    end

    for (int i = 0; i < 14; i++) send(vec[i]);
    drain();

    // start held high through DONE: second accept lands in the cycle after DONE
    @(negedge clk);
    wait_idle(0);
    drv_addr[0] = 32'h400; drv_data[0] = 64'h11111111; drv_size[0] = SZ_W;
    drv_start[0] = 1'b1;
    e2 = '{dut: 0, t0: cyc, rd: 0, wr: 1, waddr: 32'h400, wdata: 64'h11111111, err: 1'b0, lat: 2};
    exp_q.push_back(e2);
    e2.t0 = cyc + 3;
    exp_q.push_back(e2);
    repeat (4) @(negedge clk);
    drv_start[0] = 1'b0;
    drain();

    // start pulses while busy (WAIT and DONE) must be ignored
    r = '{0, 32'h100, 64'h77, SZ_B, 64'h0, 1, 1, 32'h100, 64'h00000077, 1'b0, 4};
    send(r);
    @(negedge clk); drv_start[0] = 1'b1;
    @(negedge clk); drv_start[0] = 1'b0;
    @(negedge clk); drv_start[0] = 1'b1;
    @(negedge clk); drv_start[0] = 1'b0;
    drain();
    repeat (6) @(negedge clk);

    // Reset during WAIT: outputs drop at once, no write follows
    r = '{0, 32'h103, 64'hAABBCCDD, SZ_B, 64'h11223344, 1, 1, 32'h100, 64'hDD223344, 1'b0, 4};
    send(r);
    @(negedge clk);
    chk("pre_rst_busy", 64'(if0.busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy",  64'(if0.busy), 64'd0);
    chk("mid_rst_done",  64'(if0.done), 64'd0);
    chk("mid_rst_err",   64'(if0.err), 64'd0);
    chk("mid_rst_mem_rd", 64'(if0.mem_rd), 64'd0);
    chk("mid_rst_mem_wr", 64'(if0.mem_wr), 64'd0);
    chk("mid_rst_mem_addr", 64'(if0.mem_addr), 64'd0);
    chk("mid_rst_mem_wdata", 64'(if0.mem_wdata), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    r = '{0, 32'h102, 64'h99, SZ_B, 64'h11223344, 1, 1, 32'h100, 64'h11993344, 1'b0, 4};
    send(r);
    drain();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
